// File: rtl/pipe_pkg.sv
// Shared pipeline payload bundles and stage-buffer state encoding.
// Stage buffers treat these bundles as opaque vectors; only the instantiation needs the widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL1 = 2'd1,
        ST_FULL2 = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [1:0]  jump;
        logic        halt;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        reg_write;
        logic        reg_dst;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [1:0]  jump;
        logic [31:0] alu_out;
        logic [31:0] wdata;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        halt;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_out;
        logic [31:0] mem_rdata;
        logic [4:0]  wreg;
        logic        halt;
    } mem_wb_t;

    localparam int unsigned ID_EX_W  = $bits(id_ex_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// Saturating event counter with synchronous clear; reusable for perf counters.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear wins over increment; increment holds at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter. Payload-agnostic.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned      DATA_W     = 128,
    parameter logic [DATA_W-1:0] RESET_DATA = '0,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    stage_state_e      state_q, state_d;
    logic              out_valid_d;
    logic              skid_valid, skid_valid_d;
    logic [DATA_W-1:0] out_data_d;
    logic [DATA_W-1:0] skid_data, skid_data_d;
    logic              in_ready_d;
    logic              accept_c;
    logic              pop_c;

    assign accept_c  = in_valid && in_ready;
    assign pop_c     = out_valid && out_ready;
    assign occupancy = 2'(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= RESET_DATA;
            skid_data  <= RESET_DATA;
            in_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_valid  <= out_valid_d;
            skid_valid <= skid_valid_d;
            out_data   <= out_data_d;
            skid_data  <= skid_data_d;
            in_ready   <= in_ready_d;
        end
    end

    // Occupancy FSM: main register feeds the output, skid absorbs one beat of back-pressure.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid;
        skid_valid_d = skid_valid;
        out_data_d   = out_data;
        skid_data_d  = skid_data;

        if (flush) begin
            state_d      = ST_EMPTY;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            out_data_d   = RESET_DATA;
            skid_data_d  = RESET_DATA;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        state_d     = ST_FULL1;
                    end
                end
                ST_FULL1: begin
                    if (pop_c && accept_c) begin
                        out_data_d = in_data;
                    end else if (pop_c) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_EMPTY;
                    end else if (accept_c) begin
                        skid_data_d  = in_data;
                        skid_valid_d = 1'b1;
                        state_d      = ST_FULL2;
                    end
                end
                ST_FULL2: begin
                    if (pop_c) begin
                        out_data_d   = skid_data;
                        skid_valid_d = 1'b0;
                        state_d      = ST_FULL1;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    out_valid_d  = 1'b0;
                    skid_valid_d = 1'b0;
                    out_data_d   = RESET_DATA;
                    skid_data_d  = RESET_DATA;
                end
            endcase
        end

        // Ready is a flop of "skid will be empty", so out_ready never reaches in_ready combinationally.
        in_ready_d = (state_d != ST_FULL2);
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid && !out_ready),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

    a_occ_legal: assert property (@(posedge clk) disable iff (!rst_n)
        (2'(state_q) != 2'd3));

    a_skid_implies_main: assert property (@(posedge clk) disable iff (!rst_n)
        (skid_valid |-> out_valid));

    a_occ_matches_valids: assert property (@(posedge clk) disable iff (!rst_n)
        (2'(state_q) == (2'(out_valid) + 2'(skid_valid))));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: driver pushes accepted payloads, monitor pops on each handshake.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int unsigned W = EX_MEM_W;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic [1:0]   occupancy;
    logic [15:0]  stall_cnt;
    logic         stall_clr;

    logic         s_in_valid;
    logic [7:0]   s_in_data;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [7:0]   s_out_data;
    logic         s_out_ready;
    logic [1:0]   s_occupancy;
    logic [3:0]   s_stall_cnt;
    logic         s_stall_clr;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;
    logic         rand_rdy;

    pipe_stage_buf #(.DATA_W(W), .RESET_DATA('0), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    pipe_stage_buf #(.DATA_W(8), .RESET_DATA(8'h00), .CNT_W(4)) u_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt),
        .stall_clr (s_stall_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops one expected payload per downstream handshake seen between edges.
    task automatic monitor();
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got %h expected nothing", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", out_data, e);
                end
            end
        end
    endtask

    task automatic rnd_ready();
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [W-1:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk);
            #1;
            rnd_ready();
        end
        if (k == 200) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected accept of %h", d);
        end else begin
            exp_q.push_back(d);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rnd_ready();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
            rnd_ready();
        end
        chk("drain_empty", W'(exp_q.size()), W'(0));
    endtask

    function automatic ex_mem_t rand_exmem();
        ex_mem_t r;
        r.pc         = $urandom;
        r.instr      = $urandom;
        r.reg_write  = 1'($urandom);
        r.reg_dst    = 1'($urandom);
        r.mem_read   = 1'($urandom);
        r.mem_write  = 1'($urandom);
        r.mem_to_reg = 1'($urandom);
        r.jump       = 2'($urandom);
        r.alu_out    = $urandom;
        r.wdata      = $urandom;
        r.rt         = 5'($urandom);
        r.rd         = 5'($urandom);
        r.halt       = 1'b1;
        return r;
    endfunction

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rand_rdy    = 1'b0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        stall_clr   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = 8'h00;
        s_out_ready = 1'b0;
        s_stall_clr = 1'b0;
        fork
            monitor();
        join_none

        #12;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_occupancy", W'(occupancy), W'(0));
        chk("rst_out_data", out_data, W'(0));
        chk("rst_stall_cnt", W'(stall_cnt), W'(0));
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle latency, then back-to-back stream with ready held high.
        send(W'(8'hA5));
        chk("lat_out_valid", W'(out_valid), W'(1));
        chk("lat_out_data", out_data, W'(8'hA5));
        chk("lat_occupancy", W'(occupancy), W'(1));
        for (int i = 1; i <= 8; i++) begin
            send(W'(i));
            chk("stream_in_ready", W'(in_ready), W'(1));
        end
        drain(20);

        // Back-pressure fills the skid; third item waits upstream.
        out_ready = 1'b0;
        send(W'(8'h11));
        send(W'(8'h22));
        chk("bp_occupancy", W'(occupancy), W'(2));
        chk("bp_in_ready", W'(in_ready), W'(0));
        chk("bp_out_data", out_data, W'(8'h11));
        in_valid = 1'b1;
        in_data  = W'(8'h33);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_held_occ", W'(occupancy), W'(2));
        chk("bp_held_data", out_data, W'(8'h11));
        out_ready = 1'b1;
        send(W'(8'h33));
        drain(20);

        // Flush at occupancy 2 with a same-cycle offered item.
        out_ready = 1'b0;
        send(W'(8'h11));
        send(W'(8'h22));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = W'(8'h44);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_occupancy", W'(occupancy), W'(0));
        chk("flush_out_data", out_data, W'(0));
        chk("flush_in_ready", W'(in_ready), W'(1));
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Stall counter: 20 stalled cycles, clear while stalled, 4-bit saturation.
        out_ready = 1'b0;
        send(W'(8'h77));
        stall_clr   = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h09;
        @(posedge clk);
        #1;
        stall_clr  = 1'b0;
        s_in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("stall_20", W'(stall_cnt), W'(20));
        stall_clr = 1'b1;
        @(posedge clk);
        #1;
        stall_clr = 1'b0;
        chk("stall_clr", W'(stall_cnt), W'(0));
        repeat (20) @(posedge clk);
        #1;
        chk("sat_cnt", W'(s_stall_cnt), W'(15));
        chk("sat_occ", W'(s_occupancy), W'(1));
        chk("sat_data", W'(s_out_data), W'(8'h09));
        chk("sat_valid_ready", W'({s_out_valid, s_in_ready}), W'(2'b11));
        out_ready = 1'b1;
        drain(20);

        // Async reset mid-cycle at occupancy 2.
        out_ready = 1'b0;
        send(W'(8'h11));
        send(W'(8'h22));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_in_ready", W'(in_ready), W'(1));
        chk("arst_occupancy", W'(occupancy), W'(0));
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(W'(8'h55));
        drain(20);

        // EX/MEM payloads with halt set and random downstream ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(W'(rand_exmem()));
        end
        drain(200);
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
